rx_frame_ctrl: RTL and testbench

Receive-side controller between the demodulator bit stream (bit_in/bit_sinc) and the register field write port.
- Hunts for a sync byte, then reads a length byte, payload bytes and an XOR checksum byte.
- Writes each payload byte into the register field and writes a status byte once the checksum passes.
- Raises interrupt for the host and holds it until acknowledged.

---
 rtl/rx_frame_pkg.sv | 22 ++
 rtl/rx_byte_shifter.sv | 40 ++++
 rtl/rx_frame_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rx_frame_pkg : receive-frame state encoding and default frame constants
// Rev 1.0
// -----------------------------------------------------------------------------
package rx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HUNT    = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4,
    STATUS  = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [7:0] c_DEFAULT_SYNC_WORD = 8'hA5;
  localparam int         c_DEFAULT_MAX_LEN   = 32;

endpackage
`default_nettype wire

// File: rtl/rx_byte_shifter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rx_byte_shifter : MSB-first bit assembler with 3-bit position counter
// Rev 1.0
// -----------------------------------------------------------------------------
module rx_byte_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_bit,
  input  logic       i_sinc,
  output logic [7:0] o_byte,
  output logic       o_byte_valid
);

  logic [7:0] r_sr;
  logic [2:0] r_cnt;

  // o_byte is the post-shift value on every strobe, so the sync hunt can use it too
  assign o_byte       = {r_sr[6:0], i_bit};
  assign o_byte_valid = i_sinc && (r_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= 8'h00;
      r_cnt <= 3'd0;
    end else begin
      if (i_sinc) begin
        r_sr <= o_byte;
      end
      if (i_clear) begin
        r_cnt <= 3'd0;
      end else if (i_sinc) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_frame_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rx_frame_ctrl : sync/length/payload/checksum frame receiver with RF write port
// Rev 1.0
// -----------------------------------------------------------------------------
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD   = c_DEFAULT_SYNC_WORD,
  parameter int         MAX_LEN     = c_DEFAULT_MAX_LEN,
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter logic [7:0] STATUS_ADDR = 8'hFF,
  parameter int         TIMEOUT     = 1023
) (
  input  logic       G_CLK_RX,
  input  logic       reset,
  input  logic       enable,
  input  logic       bit_in,
  input  logic       bit_sinc,
  input  logic       int_ack,
  output logic [7:0] rf_address,
  output logic [7:0] rf_data,
  output logic       rf_write_enable,
  output logic       interrupt,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_timeout
);

  localparam int              c_TW        = $clog2(TIMEOUT + 1);
  localparam logic [c_TW-1:0] c_TMO_LIMIT = c_TW'(TIMEOUT);
  localparam logic [7:0]      c_MAX_LEN_B = 8'(MAX_LEN);

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_len, w_len;
  logic [7:0]      r_idx, w_idx;
  logic [7:0]      r_chk, w_chk;
  logic [c_TW-1:0] r_tmo, w_tmo;
  logic [7:0]      r_addr, w_addr;
  logic [7:0]      r_data, w_data;
  logic            r_we, w_we;
  logic            r_int, w_int;
  logic            r_err_len, w_err_len;
  logic            r_err_chk, w_err_chk;
  logic            r_err_tmo, w_err_tmo;

  logic            w_clear;
  logic [7:0]      w_byte;
  logic            w_byte_valid;
  logic            w_tmo_active;
  logic            w_tmo_hit;

  rx_byte_shifter u_shifter (
    .clk          (G_CLK_RX),
    .rst          (reset),
    .i_clear      (w_clear),
    .i_bit        (bit_in),
    .i_sinc       (bit_sinc),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid)
  );

  assign w_tmo_active = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CHECK);
  assign w_tmo_hit    = w_tmo_active && !bit_sinc && (r_tmo == c_TMO_LIMIT);

  always_ff @(posedge G_CLK_RX) begin
    if (reset) begin
      r_state   <= IDLE;
      r_len     <= 8'h00;
      r_idx     <= 8'h00;
      r_chk     <= 8'h00;
      r_tmo     <= '0;
      r_addr    <= 8'h00;
      r_data    <= 8'h00;
      r_we      <= 1'b0;
      r_int     <= 1'b0;
      r_err_len <= 1'b0;
      r_err_chk <= 1'b0;
      r_err_tmo <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len;
      r_idx     <= w_idx;
      r_chk     <= w_chk;
      r_tmo     <= w_tmo;
      r_addr    <= w_addr;
      r_data    <= w_data;
      r_we      <= w_we;
      r_int     <= w_int;
      r_err_len <= w_err_len;
      r_err_chk <= w_err_chk;
      r_err_tmo <= w_err_tmo;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len       = r_len;
    w_idx       = r_idx;
    w_chk       = r_chk;
    w_tmo       = (w_tmo_active && !bit_sinc && !w_tmo_hit) ? r_tmo + c_TW'(1) : '0;
    w_addr      = 8'h00;
    w_data      = 8'h00;
    w_we        = 1'b0;
    w_int       = r_int;
    w_err_len   = 1'b0;
    w_err_chk   = 1'b0;
    w_err_tmo   = 1'b0;
    w_clear     = 1'b0;

    case (r_state)
      IDLE: begin
        w_clear = 1'b1;
        if (enable) w_state_nxt = HUNT;
      end
      HUNT: begin
        if (bit_sinc && (w_byte == SYNC_WORD)) begin
          w_clear     = 1'b1;
          w_state_nxt = LEN;
        end
      end
      LEN: begin
        if (w_tmo_hit) begin
          w_err_tmo   = 1'b1;
          w_state_nxt = HUNT;
        end else if (w_byte_valid) begin
          if ((w_byte == 8'h00) || (w_byte > c_MAX_LEN_B)) begin
            w_err_len   = 1'b1;
            w_state_nxt = HUNT;
          end else begin
            w_len       = w_byte;
            w_idx       = 8'h00;
            w_chk       = 8'h00;
            w_state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (w_tmo_hit) begin
          w_err_tmo   = 1'b1;
          w_state_nxt = HUNT;
        end else if (w_byte_valid) begin
          w_addr = BASE_ADDR + r_idx;
          w_data = w_byte;
          w_we   = 1'b1;
          w_chk  = r_chk ^ w_byte;
          w_idx  = r_idx + 8'd1;
          if ((r_idx + 8'd1) == r_len) w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (w_tmo_hit) begin
          w_err_tmo   = 1'b1;
          w_state_nxt = HUNT;
        end else if (w_byte_valid) begin
          if (w_byte == r_chk) begin
            // status write is registered here so it lands during the STATUS cycle
            w_addr      = STATUS_ADDR;
            w_data      = r_len;
            w_we        = 1'b1;
            w_state_nxt = STATUS;
          end else begin
            w_err_chk   = 1'b1;
            w_state_nxt = HUNT;
          end
        end
      end
      STATUS: begin
        w_int       = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        if (int_ack) begin
          w_int       = 1'b0;
          w_state_nxt = HUNT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // disabling aborts silently; a frame not yet in DONE never raises interrupt
    if (!enable) begin
      w_state_nxt = IDLE;
      w_we        = 1'b0;
      w_addr      = 8'h00;
      w_data      = 8'h00;
      w_err_len   = 1'b0;
      w_err_chk   = 1'b0;
      w_err_tmo   = 1'b0;
      if (r_state == STATUS) w_int = r_int;
    end
  end

  assign rf_address      = r_addr;
  assign rf_data         = r_data;
  assign rf_write_enable = r_we;
  assign interrupt       = r_int;
  assign err_len         = r_err_len;
  assign err_chk         = r_err_chk;
  assign err_timeout     = r_err_tmo;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_rx_frame_ctrl : scoreboard bench for rx_frame_ctrl
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_rx_frame_ctrl;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       bit_in;
  logic       bit_sinc;
  logic       int_ack;
  logic [7:0] rf_address;
  logic [7:0] rf_data;
  logic       rf_write_enable;
  logic       interrupt;
  logic       err_len;
  logic       err_chk;
  logic       err_timeout;

  rx_frame_ctrl dut (
    .G_CLK_RX        (clk),
    .reset           (reset),
    .enable          (enable),
    .bit_in          (bit_in),
    .bit_sinc        (bit_sinc),
    .int_ack         (int_ack),
    .rf_address      (rf_address),
    .rf_data         (rf_data),
    .rf_write_enable (rf_write_enable),
    .interrupt       (interrupt),
    .err_len         (err_len),
    .err_chk         (err_chk),
    .err_timeout     (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {EV_WRITE, EV_ERR_LEN, EV_ERR_CHK, EV_ERR_TMO, EV_INT} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  logic prev_int = 1'b0;

  task automatic push(input ev_kind_t k, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input ev_kind_t k, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_%s: got addr=%02h data=%02h with nothing expected", k.name(), a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a || e.data != d) begin
        n_errors++;
        $display("FAIL event: got %s addr=%02h data=%02h expected %s addr=%02h data=%02h",
                 k.name(), a, d, e.kind.name(), e.addr, e.data);
      end
    end
  endtask

  // monitor: every output event is matched against the head of the queue
  always @(negedge clk) begin
    if (rf_write_enable) pop_check(EV_WRITE, rf_address, rf_data);
    if (err_len)         pop_check(EV_ERR_LEN, 8'h00, 8'h00);
    if (err_chk)         pop_check(EV_ERR_CHK, 8'h00, 8'h00);
    if (err_timeout)     pop_check(EV_ERR_TMO, 8'h00, 8'h00);
    if (interrupt && !prev_int) pop_check(EV_INT, 8'h00, 8'h00);
    prev_int = interrupt;
  end

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    bit_in   = b;
    bit_sinc = 1'b1;
    @(posedge clk); #1;
    bit_sinc = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    idle_cycles(2);
    check(name, exp_q.size(), 0);
  endtask

  task automatic ack_irq(input string name);
    @(posedge clk); #1;
    int_ack = 1'b1;
    @(posedge clk); #1;
    int_ack = 1'b0;
    check(name, interrupt, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    bit_in   = 1'b0;
    bit_sinc = 1'b0;
    int_ack  = 1'b0;
    idle_cycles(3);
    check("reset_outputs",
          {rf_address, rf_data, rf_write_enable, interrupt, err_len, err_chk, err_timeout}, 0);
    @(posedge clk); #1;
    reset  = 1'b0;
    enable = 1'b1;
    idle_cycles(2);

    // good frame: checksum 11^22^33 = 00
    push(EV_WRITE, 8'h00, 8'h11);
    push(EV_WRITE, 8'h01, 8'h22);
    push(EV_WRITE, 8'h02, 8'h33);
    push(EV_WRITE, 8'hFF, 8'h03);
    push(EV_INT, 8'h00, 8'h00);
    send_byte(8'hA5); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h00);
    check("status_strobe_latency", {rf_write_enable, rf_address, rf_data}, {1'b1, 8'hFF, 8'h03});
    check("int_not_yet", interrupt, 1'b0);
    @(posedge clk); #1;
    check("int_latency", interrupt, 1'b1);
    idle_cycles(5);
    check("int_held", interrupt, 1'b1);
    ack_irq("int_ack_clears");
    wait_drain("good_frame_drain", 10);

    // bad checksum: 5A^5A = 00, sent 01
    push(EV_WRITE, 8'h00, 8'h5A);
    push(EV_WRITE, 8'h01, 8'h5A);
    push(EV_ERR_CHK, 8'h00, 8'h00);
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h5A); send_byte(8'h5A);
    send_byte(8'h01);
    wait_drain("bad_chk_drain", 10);
    check("bad_chk_no_int", interrupt, 1'b0);

    // illegal lengths 0 and MAX_LEN+1
    push(EV_ERR_LEN, 8'h00, 8'h00);
    send_byte(8'hA5); send_byte(8'h00);
    wait_drain("len_zero_drain", 10);
    push(EV_ERR_LEN, 8'h00, 8'h00);
    send_byte(8'hA5); send_byte(8'h21);
    wait_drain("len_big_drain", 10);

    // timeout after first payload byte: error appears 1024 edges after the last strobe
    push(EV_WRITE, 8'h00, 8'h10);
    push(EV_ERR_TMO, 8'h00, 8'h00);
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h10);
    idle_cycles(1020);
    check("tmo_not_early", exp_q.size(), 1);
    wait_drain("tmo_drain", 40);
    push(EV_WRITE, 8'h00, 8'h7E);
    push(EV_WRITE, 8'hFF, 8'h01);
    push(EV_INT, 8'h00, 8'h00);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7E);
    wait_drain("after_tmo_frame", 10);
    ack_irq("after_tmo_ack");

    // sync hunt through garbage containing a near-miss 1010_0100
    push(EV_WRITE, 8'h00, 8'hC3);
    push(EV_WRITE, 8'h01, 8'h3C);
    push(EV_WRITE, 8'hFF, 8'h02);
    push(EV_INT, 8'h00, 8'h00);
    send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC3); send_byte(8'h3C);
    send_byte(8'hFF);
    wait_drain("hunt_frame", 10);
    ack_irq("hunt_ack");

    // enable dropped mid-payload: the following byte must not be written
    push(EV_WRITE, 8'h00, 8'h11);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    @(posedge clk); #1;
    enable = 1'b0;
    send_byte(8'h22);
    wait_drain("disable_drain", 10);
    enable = 1'b1;
    idle_cycles(2);

    // reset coincident with the strobe completing a payload byte
    push(EV_WRITE, 8'h00, 8'h44);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h44);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h55 >> i));
    @(posedge clk); #1;
    bit_in   = 1'b1;
    bit_sinc = 1'b1;
    reset    = 1'b1;
    @(posedge clk); #1;
    bit_sinc = 1'b0;
    check("reset_cycle_outputs",
          {rf_address, rf_data, rf_write_enable, interrupt, err_len, err_chk, err_timeout}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(3);
    check("post_reset_outputs",
          {rf_address, rf_data, rf_write_enable, interrupt, err_len, err_chk, err_timeout}, 0);
    wait_drain("reset_drain", 5);

    // receiver recovers after reset
    push(EV_WRITE, 8'h00, 8'h99);
    push(EV_WRITE, 8'hFF, 8'h01);
    push(EV_INT, 8'h00, 8'h00);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h99); send_byte(8'h99);
    wait_drain("recover_frame", 10);
    ack_irq("recover_ack");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
